// File: rtl/benes_pkg.sv
// Shared helpers for the Benes permutation network: stage count, per-stage
// butterfly order and the number of registered stages ahead of a stage.
package benes_pkg;

  function automatic int benes_stages(input int lanes);
    return 2 * $clog2(lanes) - 1;
  endfunction

  // Orders run log2(L)-1 down to 0 and back up again.
  function automatic int stage_order(input int lanes, input int s);
    int mid;
    mid = $clog2(lanes) - 1;
    return (s >= mid) ? (s - mid) : (mid - s);
  endfunction

  function automatic int carry_depth(input logic [63:0] mask, input int s);
    int n;
    n = 0;
    for (int k = 0; k < s; k++) n += int'(mask[k]);
    return n;
  endfunction

endpackage

// File: rtl/benes_permute_net_if.sv
// Beat bus of the permutation network: input beat in, permuted beat plus
// its configuration epoch out. No backpressure in either direction.
interface benes_permute_net_if #(
  parameter int LANES   = 32,
  parameter int ELEM_W  = 1,
  parameter int EPOCH_W = 8
) ();
  logic                      in_valid;
  logic [LANES*ELEM_W-1:0]   din;
  logic                      out_valid;
  logic [LANES*ELEM_W-1:0]   dout;
  logic [EPOCH_W-1:0]        out_epoch;

  modport master (output in_valid, din, input out_valid, dout, out_epoch);
  modport slave  (input in_valid, din, output out_valid, dout, out_epoch);
endinterface

// File: rtl/benes_stage.sv
// One column of 2x2 switches; optional output register (0 or 1 cycle).
// Consumes the lowest config word and forwards the remaining words with the beat.
module benes_stage
  import benes_pkg::*;
#(
  parameter int LANES    = 32,
  parameter int ELEM_W   = 1,
  parameter int ORDER    = 0,
  parameter bit IS_PIPED = 1'b1,
  parameter int EPOCH_W  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [LANES*ELEM_W-1:0]                  din_i,
  input  logic                                     vld_i,
  input  logic [EPOCH_W-1:0]                       ep_i,
  input  logic [benes_stages(LANES)*(LANES/2)-1:0] cfg_i,
  output logic [LANES*ELEM_W-1:0]                  dat_o,
  output logic                                     vld_o,
  output logic [EPOCH_W-1:0]                       ep_o,
  output logic [benes_stages(LANES)*(LANES/2)-1:0] cfg_o
);
  localparam int HALF  = LANES / 2;
  localparam int W     = LANES * ELEM_W;
  localparam int CFG_W = benes_stages(LANES) * HALF;
  localparam int SHIFT = 1 << ORDER;

  logic [W-1:0]     dat_d;
  logic [CFG_W-1:0] cfg_d;

  function automatic int lane_a(input int k);
    return 2 * SHIFT * (k / SHIFT) + (k % SHIFT);
  endfunction

  always_comb begin
    dat_d = din_i;
    for (int k = 0; k < HALF; k++) begin
      if (cfg_i[k]) begin
        dat_d[lane_a(k)*ELEM_W +: ELEM_W]         = din_i[(lane_a(k)+SHIFT)*ELEM_W +: ELEM_W];
        dat_d[(lane_a(k)+SHIFT)*ELEM_W +: ELEM_W] = din_i[lane_a(k)*ELEM_W +: ELEM_W];
      end
    end
  end

  // Downstream stages see their own word at the bottom of the carried vector.
  assign cfg_d = {{HALF{1'b0}}, cfg_i[CFG_W-1:HALF]};

  if (IS_PIPED) begin : g_reg
    logic [W-1:0]       dat_q;
    logic               vld_q;
    logic [EPOCH_W-1:0] ep_q;
    logic [CFG_W-1:0]   cfg_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q <= '0;
        vld_q <= 1'b0;
        ep_q  <= '0;
        cfg_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_i;
        ep_q  <= ep_i;
        cfg_q <= cfg_d;
      end
    end

    assign dat_o = dat_q;
    assign vld_o = vld_q;
    assign ep_o  = ep_q;
    assign cfg_o = cfg_q;
  end else begin : g_comb
    logic clk_rst_unused;
    assign clk_rst_unused = clk ^ rst;
    assign dat_o = dat_d;
    assign vld_o = vld_i;
    assign ep_o  = ep_i;
    assign cfg_o = cfg_d;
  end
endmodule

// File: rtl/benes_permute_net.sv
// Beats are permuted by the config active when accepted; latency = popcount(PIPE_MASK).
// Always accepts a beat every cycle; commits swap shadow->active atomically.
module benes_permute_net
  import benes_pkg::*;
#(
  parameter int                           LANES     = 32,
  parameter int                           ELEM_W    = 1,
  parameter logic [2*$clog2(LANES)-2:0]   PIPE_MASK = '1,
  parameter int                           EPOCH_W   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_wr_en,
  input  logic [$clog2(benes_stages(LANES))-1:0] cfg_wr_stage,
  input  logic [LANES/2-1:0]                   cfg_wr_data,
  input  logic                                 cfg_commit,
  output logic [EPOCH_W-1:0]                   cfg_epoch,
  benes_permute_net_if.slave                   bus
);
  localparam int STAGES = benes_stages(LANES);
  localparam int HALF   = LANES / 2;
  localparam int W      = LANES * ELEM_W;
  localparam int CFG_W  = STAGES * HALF;

  logic [HALF-1:0]    shadow_q [STAGES];
  logic [HALF-1:0]    shadow_d [STAGES];
  logic [CFG_W-1:0]   active_q, active_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  // Commit copies the post-write shadow so a same-cycle write is included.
  always_comb begin
    active_d = active_q;
    epoch_d  = epoch_q;
    for (int s = 0; s < STAGES; s++) begin
      shadow_d[s] = shadow_q[s];
      if (cfg_wr_en && int'(cfg_wr_stage) == s) shadow_d[s] = cfg_wr_data;
    end
    if (cfg_commit) begin
      for (int s = 0; s < STAGES; s++) active_d[s*HALF +: HALF] = shadow_d[s];
      epoch_d = epoch_q + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) shadow_q[s] <= '0;
      active_q <= '0;
      epoch_q  <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) shadow_q[s] <= shadow_d[s];
      active_q <= active_d;
      epoch_q  <= epoch_d;
    end
  end

  assign cfg_epoch = epoch_q;

  logic [W-1:0]       dat_c [STAGES+1];
  logic               vld_c [STAGES+1];
  logic [EPOCH_W-1:0] ep_c  [STAGES+1];
  logic [CFG_W-1:0]   cfg_c [STAGES+1];
  logic [CFG_W-1:0]   cfg_tail_unused;

  assign dat_c[0] = bus.din;
  assign vld_c[0] = bus.in_valid;
  assign ep_c[0]  = epoch_q;
  assign cfg_c[0] = active_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    benes_stage #(
      .LANES    (LANES),
      .ELEM_W   (ELEM_W),
      .ORDER    (stage_order(LANES, s)),
      .IS_PIPED (PIPE_MASK[s]),
      .EPOCH_W  (EPOCH_W)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .din_i (dat_c[s]),
      .vld_i (vld_c[s]),
      .ep_i  (ep_c[s]),
      .cfg_i (cfg_c[s]),
      .dat_o (dat_c[s+1]),
      .vld_o (vld_c[s+1]),
      .ep_o  (ep_c[s+1]),
      .cfg_o (cfg_c[s+1])
    );
  end

  assign cfg_tail_unused = cfg_c[STAGES];
  assign bus.dout        = dat_c[STAGES];
  assign bus.out_valid   = vld_c[STAGES];
  assign bus.out_epoch   = ep_c[STAGES];
endmodule

// File: tb/tb_benes_permute_net.sv
// Bench for benes_permute_net: a fully piped and a fully combinational 8x8-bit
// instance share stimulus; a lane-swap reference model feeds per-DUT scoreboards.
module tb_benes_permute_net;
  localparam int LAT_P = $countones(5'b11111);
  localparam int LAT_C = 0;
  localparam logic [63:0] ID_BEAT = 64'h0706050403020100;

  typedef struct {
    logic [63:0] d;
    int          e;
    int          base;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr_en, cfg_commit;
  logic [2:0] cfg_wr_stage;
  logic [3:0] cfg_wr_data;
  logic [7:0] cfg_epoch_p;
  logic [1:0] cfg_epoch_c;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  benes_permute_net_if #(.LANES(8), .ELEM_W(8), .EPOCH_W(8)) bus_p ();
  benes_permute_net_if #(.LANES(8), .ELEM_W(8), .EPOCH_W(2)) bus_c ();

  benes_permute_net #(.LANES(8), .ELEM_W(8), .PIPE_MASK(5'b11111), .EPOCH_W(8)) dut_p (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_stage(cfg_wr_stage),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .cfg_epoch(cfg_epoch_p), .bus(bus_p));

  benes_permute_net #(.LANES(8), .ELEM_W(8), .PIPE_MASK(5'b00000), .EPOCH_W(2)) dut_c (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_stage(cfg_wr_stage),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .cfg_epoch(cfg_epoch_c), .bus(bus_c));

  int n_vec = 0;
  int n_bad = 0;
  exp_t q_p[$];
  exp_t q_c[$];
  exp_t mon_p, mon_c;

  logic [4:0][3:0] m_shadow, m_active;
  int m_epoch;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: lanes as an array, each stage swaps the pairs its set bits select.
  function automatic logic [63:0] model_permute(input logic [63:0] x, input logic [4:0][3:0] cfg);
    logic [7:0]  ln [8];
    logic [7:0]  t;
    logic [63:0] r;
    int sh, a, b;
    for (int k = 0; k < 8; k++) ln[k] = x[k*8 +: 8];
    for (int s = 0; s < 5; s++) begin
      sh = (s < 2) ? (1 << (2 - s)) : (1 << (s - 2));
      for (int k = 0; k < 4; k++) begin
        if (cfg[s][k]) begin
          a = 2 * sh * (k / sh) + (k % sh);
          b = a + sh;
          t = ln[a]; ln[a] = ln[b]; ln[b] = t;
        end
      end
    end
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = ln[k];
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (bus_p.out_valid) begin
      if (q_p.size() == 0) begin
        check("piped_spurious_beat", 64'(bus_p.out_valid), 64'd0);
      end else begin
        mon_p = q_p.pop_front();
        check("piped_dout", bus_p.dout, mon_p.d);
        check("piped_out_epoch", 64'(bus_p.out_epoch), 64'(mon_p.e % 256));
        check("piped_latency", 64'(cyc), 64'(mon_p.base + LAT_P));
      end
    end else if (q_p.size() > 0 && q_p[0].base + LAT_P <= cyc) begin
      mon_p = q_p.pop_front();
      check("piped_missing_beat", 64'(bus_p.out_valid), 64'd1);
    end
    if (bus_c.out_valid) begin
      if (q_c.size() == 0) begin
        check("comb_spurious_beat", 64'(bus_c.out_valid), 64'd0);
      end else begin
        mon_c = q_c.pop_front();
        check("comb_dout", bus_c.dout, mon_c.d);
        check("comb_out_epoch", 64'(bus_c.out_epoch), 64'(mon_c.e % 4));
        check("comb_latency", 64'(cyc), 64'(mon_c.base + LAT_C));
      end
    end else if (q_c.size() > 0 && q_c[0].base + LAT_C <= cyc) begin
      mon_c = q_c.pop_front();
      check("comb_missing_beat", 64'(bus_c.out_valid), 64'd1);
    end
  end

  task automatic step(input bit v, input logic [63:0] d, input bit we,
                      input logic [2:0] ws, input logic [3:0] wd, input bit cm);
    exp_t e;
    bus_p.in_valid = v; bus_c.in_valid = v;
    bus_p.din = d;      bus_c.din = d;
    cfg_wr_en = we; cfg_wr_stage = ws; cfg_wr_data = wd; cfg_commit = cm;
    if (v) begin
      e.d = model_permute(d, m_active);
      e.e = m_epoch;
      e.base = cyc;
      q_p.push_back(e);
      q_c.push_back(e);
    end
    if (we && ws < 3'd5) m_shadow[ws] = wd;
    if (cm) begin
      m_active = m_shadow;
      m_epoch = (m_epoch + 1) % 256;
    end
    @(posedge clk); #1;
    check("cfg_epoch_piped", 64'(cfg_epoch_p), 64'(m_epoch % 256));
    check("cfg_epoch_comb", 64'(cfg_epoch_c), 64'(m_epoch % 4));
  endtask

  // Reset with config traffic and garbage data on the bus, all of which must be ignored.
  task automatic do_reset(input int n);
    rst = 1'b1;
    bus_p.in_valid = 1'b0; bus_c.in_valid = 1'b0;
    bus_p.din = rand64(); bus_c.din = bus_p.din;
    cfg_wr_en = 1'b1; cfg_wr_stage = 3'd0; cfg_wr_data = 4'hF; cfg_commit = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    q_p.delete(); q_c.delete();
    m_shadow = '0; m_active = '0; m_epoch = 0;
    check("rst_out_valid_piped", 64'(bus_p.out_valid), 64'd0);
    check("rst_dout_piped", bus_p.dout, 64'd0);
    check("rst_out_epoch_piped", 64'(bus_p.out_epoch), 64'd0);
    check("rst_out_valid_comb", 64'(bus_c.out_valid), 64'd0);
    check("rst_cfg_epoch_piped", 64'(cfg_epoch_p), 64'd0);
    check("rst_cfg_epoch_comb", 64'(cfg_epoch_c), 64'd0);
    rst = 1'b0;
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // Identity after reset.
    step(1, ID_BEAT, 0, 3'd0, 4'h0, 0);
    repeat (6) step(0, 64'd0, 0, 3'd0, 4'h0, 0);

    // Reversal: stages 0-2 cross, 3-4 bar, commit together with the last write.
    for (int s = 0; s < 5; s++) step(0, 64'd0, 1, 3'(s), (s < 3) ? 4'hF : 4'h0, s == 4);
    step(1, ID_BEAT, 0, 3'd0, 4'h0, 0);
    step(1, rand64(), 0, 3'd0, 4'h0, 0);

    // Back to identity, then commit reversal in the middle of a continuous stream.
    for (int s = 0; s < 5; s++) step(0, 64'd0, 1, 3'(s), 4'h0, s == 4);
    for (int i = 0; i < 21; i++)
      step(1, (i % 2 == 0) ? ID_BEAT : rand64(), i < 5, 3'(i), (i < 3) ? 4'hF : 4'h0, i == 10);

    // Same-cycle write and commit: only stage 4 switch 0 crosses (lanes 0 and 4).
    for (int s = 0; s < 4; s++) step(0, 64'd0, 1, 3'(s), 4'h0, 0);
    step(1, ID_BEAT, 1, 3'd4, 4'h1, 1);
    step(1, ID_BEAT, 0, 3'd0, 4'h0, 0);

    // Out-of-range stage writes are dropped but commits still bump the epoch.
    step(0, 64'd0, 1, 3'd4, 4'h0, 1);
    step(0, 64'd0, 1, 3'd5, 4'hF, 0);
    step(1, ID_BEAT, 0, 3'd0, 4'h0, 1);
    step(1, ID_BEAT, 1, 3'd7, 4'hF, 1);
    step(1, rand64(), 0, 3'd0, 4'h0, 0);

    // Four commits wrap the 2-bit epoch of the combinational instance.
    repeat (4) step(0, 64'd0, 0, 3'd0, 4'h0, 1);
    step(1, ID_BEAT, 0, 3'd0, 4'h0, 0);

    // Reversal active, three beats in flight, then reset drops them.
    for (int s = 0; s < 5; s++) step(0, 64'd0, 1, 3'(s), (s < 3) ? 4'hF : 4'h0, s == 4);
    repeat (6) step(0, 64'd0, 0, 3'd0, 4'h0, 0);
    repeat (3) step(1, rand64(), 0, 3'd0, 4'h0, 0);
    do_reset(1);
    repeat (LAT_P + 2) step(0, 64'd0, 0, 3'd0, 4'h0, 0);

    // Random traffic: beats, writes (including illegal stages) and commits.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand64(), $urandom_range(0, 2) == 0,
           3'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 9) == 0);

    repeat (LAT_P + 3) step(0, 64'd0, 0, 3'd0, 4'h0, 0);
    check("piped_drain", 64'(q_p.size()), 64'd0);
    check("comb_drain", 64'(q_c.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/benes_permute_net.md
# benes_permute_net

Fully configurable N-lane Beneš permutation network built from 2x2 butterfly switch stages, with per-stage pipeline selection, a double-buffered runtime configuration and valid/epoch tracking. It sits in the parser datapath wherever header fields or bytes are reordered, and replaces hand-chained single butterfly stages. Each input beat is permuted by the configuration that was active on the cycle the beat was accepted. Configuration updates never produce a beat with a mixed configuration.

## Interface
- LANES, 32: lane count. Power of two, ≥4.
- ELEM_W, 1: bits per lane.
- PIPE_MASK, all ones (STAGES bits): bit s=1 registers the output of stage s.
- EPOCH_W, 8: width of the configuration epoch counter.
- STAGES (derived localparam): 2·log2(LANES)−1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_wr_en  in  1  write one stage word into the shadow config
- cfg_wr_stage  in  $clog2(STAGES)  target stage index
- cfg_wr_data  in  LANES/2  switch bits for that stage; 1 = cross, 0 = bar
- cfg_commit  in  1  copy shadow config to active; increment epoch
- cfg_epoch  out  EPOCH_W  current active epoch
- in_valid  in  1  input beat valid; always accepted, no backpressure
- din  in  LANES·ELEM_W  lane k occupies bits [k·ELEM_W +: ELEM_W]
- out_valid  out  1  output beat valid
- dout  out  LANES·ELEM_W  permuted beat
- out_epoch  out  EPOCH_W  epoch used to permute this beat

## Operation
- Stage s uses order o(s) = |s − (log2(LANES)−1)|, with SHIFT = 2^o. Switch index (i·SHIFT + j), for region i and j < SHIFT, pairs lane a = 2·SHIFT·i + j with lane b = a + SHIFT.
- With its config bit set, a switch swaps lanes a and b. With the bit clear, both lanes pass straight through.
- The shadow config holds STAGES words of LANES/2 bits. A write with cfg_wr_stage ≥ STAGES is ignored.
- On cfg_commit, active ← shadow and cfg_epoch ← cfg_epoch+1, wrapping modulo 2^EPOCH_W. If a write and a commit occur in the same cycle, the committed config includes that write.
- A beat accepted in cycle t uses the active config before that edge. A commit in cycle t therefore affects beats from t+1 onward.
- Each stage's config slice and the epoch travel down the pipeline with the beat. In-flight beats are unaffected by later commits.
- Data is propagated regardless of in_valid. Only the valid bit marks beats.

## Timing
- Latency is popcount(PIPE_MASK) cycles. When PIPE_MASK=0, the path from din to dout is combinational, with out_valid = in_valid.
- Throughput is one beat per cycle.
- Reset values:
  - shadow and active config = 0, which gives the identity permutation.
  - cfg_epoch = 0.
  - All pipeline valid, data and epoch registers = 0, so out_valid=0, dout=0 and out_epoch=0.
- Reset mid-stream: all in-flight beats are dropped, and out_valid is 0 from the first cycle after the reset edge. A cfg_wr_en or cfg_commit coincident with rst is ignored.
- The stage-to-stage config and epoch carry registers exist only for stages with PIPE_MASK=1.

## Structure
- Package benes_pkg:
  - function for the stage count from LANES.
  - function o(s) for the stage order.
  - function for the carry depth of each stage (the number of registered stages before s).
- Sub-module benes_stage, one per stage:
  - Parameters: LANES, ELEM_W, ORDER, IS_PIPED, EPOCH_W.
  - Carries din, valid, epoch and the config words of all downstream stages.
  - Generated STAGES times in benes_permute_net.
- The top level holds the shadow/active config registers, the epoch counter and the write decode.

## Test plan
- Reset identity: LANES=8, ELEM_W=8, PIPE_MASK=5'b11111. Drive din lanes 0..7 = 0x00..0x07 with in_valid=1. Required: out_valid after 5 cycles, dout lanes = 0x00..0x07, out_epoch=0.
- Reversal: write stages 0–2 = 4'hF and stages 3–4 = 4'h0, then commit. For lanes 0..7 = 0x00..0x07, required dout lanes = 0x07..0x00 and out_epoch=1.
- Commit mid-stream: drive continuous beats and commit the reversal config at cycle 10. Beats accepted ≤10 must be identity with epoch 0; beats from 11 on must be reversed with epoch 1. No beat may show a partial swap.
- Same-cycle write+commit: write stage 4 = 4'h1 together with cfg_commit. The next beat must swap lanes 0 and 4, and cfg_epoch must increment by exactly 1.
- Illegal writes and reset:
  - cfg_wr_stage=5 then commit: output stays identity, while the epoch still increments.
  - rst asserted while 3 beats are in flight: out_valid=0 on the next cycle, and those beats never appear.
- PIPE_MASK=0: out_valid and dout follow in_valid and din in the same cycle under the reversal config. With EPOCH_W=2, four commits wrap the epoch to 0.
